// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pong_pkg
// Brief   : Shared state encoding and player constants for the pong scorer.
// Revision: 1.0
// ============================================================================
package pong_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_PLAY_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC = 2'd2;
  localparam logic [1:0] ST_OVER_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    PLAY = ST_PLAY_ENC,
    HOLD = ST_HOLD_ENC,
    OVER = ST_OVER_ENC
  } state_t;

  // serve_side encoding: the value names the player who serves
  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  // length of the goal animation; HOLDOFF must cover it
  localparam int ANIM_CYCLES = 30;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module  : rise_detect
// Brief   : 1-bit rising-edge detector; previous level registered every cycle.
// Revision: 1.0
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module  : score_keeper
// Brief   : Converts ball-out levels into scores, goal/win pulses and play gating.
// Revision: 1.0
// ============================================================================
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE = 5,
  parameter int SCORE_W   = 4,
  parameter int HOLDOFF   = 32
) (
  input  logic               BALL_CLOCK,
  input  logic               RESET,
  input  logic               start,
  input  logic               ball_out_left,
  input  logic               ball_out_right,
  output logic               play_active,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               goal_player_1,
  output logic               goal_player_2,
  output logic               win_player_1,
  output logic               win_player_2
);

  localparam int                 CNT_W     = $clog2(HOLDOFF);
  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(HOLDOFF - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

  logic rise_l;
  logic rise_r;

  rise_detect u_rise_left (
    .clk  (BALL_CLOCK),
    .rst  (RESET),
    .d    (ball_out_left),
    .rise (rise_l)
  );

  rise_detect u_rise_right (
    .clk  (BALL_CLOCK),
    .rst  (RESET),
    .d    (ball_out_right),
    .rise (rise_r)
  );

  state_t             state_q,       state_d;
  logic [SCORE_W-1:0] score_1_q,     score_1_d;
  logic [SCORE_W-1:0] score_2_q,     score_2_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic               serve_q,       serve_d;
  logic               play_active_q, play_active_d;
  logic               goal_1_q,      goal_1_d;
  logic               goal_2_q,      goal_2_d;
  logic               win_1_q,       win_1_d;
  logic               win_2_q,       win_2_d;
  logic [SCORE_W-1:0] inc_1;
  logic [SCORE_W-1:0] inc_2;

  assign inc_1 = score_1_q + ONE;
  assign inc_2 = score_2_q + ONE;

  always_comb begin
    state_d   = state_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    cnt_d     = cnt_q;
    serve_d   = serve_q;
    goal_1_d  = 1'b0;
    goal_2_d  = 1'b0;
    win_1_d   = 1'b0;
    win_2_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        // simultaneous rises are treated as a sensor fault and dropped
        if (rise_r && !rise_l) begin
          score_1_d = inc_1;
          serve_d   = PLAYER_2;
          if (inc_1 == WIN_VAL) begin
            win_1_d = 1'b1;
            state_d = OVER;
          end else begin
            goal_1_d = 1'b1;
            cnt_d    = HOLD_INIT;
            state_d  = HOLD;
          end
        end else if (rise_l && !rise_r) begin
          score_2_d = inc_2;
          serve_d   = PLAYER_1;
          if (inc_2 == WIN_VAL) begin
            win_2_d = 1'b1;
            state_d = OVER;
          end else begin
            goal_2_d = 1'b1;
            cnt_d    = HOLD_INIT;
            state_d  = HOLD;
          end
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      OVER: begin
        if (start) begin
          score_1_d = '0;
          score_2_d = '0;
          serve_d   = PLAYER_1;
          state_d   = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    play_active_d = (state_d == PLAY);
  end

  always_ff @(posedge BALL_CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      score_1_q     <= '0;
      score_2_q     <= '0;
      cnt_q         <= '0;
      serve_q       <= PLAYER_1;
      play_active_q <= 1'b0;
      goal_1_q      <= 1'b0;
      goal_2_q      <= 1'b0;
      win_1_q       <= 1'b0;
      win_2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_1_q     <= score_1_d;
      score_2_q     <= score_2_d;
      cnt_q         <= cnt_d;
      serve_q       <= serve_d;
      play_active_q <= play_active_d;
      goal_1_q      <= goal_1_d;
      goal_2_q      <= goal_2_d;
      win_1_q       <= win_1_d;
      win_2_q       <= win_2_d;
    end
  end

  assign play_active   = play_active_q;
  assign serve_side    = serve_q;
  assign score_1       = score_1_q;
  assign score_2       = score_2_q;
  assign goal_player_1 = goal_1_q;
  assign goal_player_2 = goal_2_q;
  assign win_player_1  = win_1_q;
  assign win_player_2  = win_2_q;

endmodule : score_keeper
`default_nettype wire
